// File: rtl/acc_core_mc.sv
// acc_core_mc: multi-channel burst accumulator.
// A run_i pulse clears all channel accumulators and latches the burst length and the
// arithmetic mode. Tagged samples are then summed into their channels until len samples
// have been accepted. After that every channel result is drained, one per cycle, together
// with its sticky overflow flag.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   run_i, len_i            start/restart pulse and burst length (samples over all channels)
//   signed_i, sat_i         operand signedness and saturate/wrap select, latched on run_i
//   valid_i, ch_i, number_i sample strobe, target channel, operand
//   busy_o                  high while accumulating or draining
//   valid_o, last_o, ch_o   drain beat strobe, final beat marker, beat channel
//   result_o, ovf_o         channel accumulator value and sticky overflow flag
module acc_core_mc #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run_i,
  input  logic [CNT_WIDTH-1:0]     len_i,
  input  logic                     signed_i,
  input  logic                     sat_i,
  input  logic                     valid_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic [IN_DATA_WIDTH-1:0] number_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic [CH_W-1:0]          ch_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     ovf_o
);

  typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

  localparam logic [CH_W:0]   ChLimit = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] ChLast  = CH_W'(NUM_CH - 1);

  state_e               r_state;
  logic [DWIDTH-1:0]    r_acc [NUM_CH];
  logic [NUM_CH-1:0]    r_ovf;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_len;
  logic                 r_signed;
  logic                 r_sat;
  logic [CH_W-1:0]      r_idx;

  logic                 w_ch_ok;
  logic                 w_accept;
  logic [CH_W-1:0]      w_sel_ch;
  logic [DWIDTH-1:0]    w_cur;
  logic [DWIDTH:0]      w_cur_ext;
  logic [DWIDTH:0]      w_opnd;
  logic [DWIDTH:0]      w_sum;
  logic                 w_oor;
  logic [DWIDTH-1:0]    w_new;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  always_comb begin
    w_ch_ok   = ({1'b0, ch_i} < ChLimit);
    w_accept  = (r_state == StAcc) && valid_i && w_ch_ok && !run_i;
    // Dropped channel indices never address the array.
    w_sel_ch  = w_ch_ok ? ch_i : '0;
    w_cur     = r_acc[w_sel_ch];
    w_cur_ext = {r_signed & w_cur[DWIDTH-1], w_cur};
    w_opnd    = {{(DWIDTH + 1 - IN_DATA_WIDTH){r_signed & number_i[IN_DATA_WIDTH-1]}}, number_i};
    w_sum     = w_cur_ext + w_opnd;
    // Signed: the two top bits of the widened sum disagree exactly when it left range.
    w_oor     = r_signed ? (w_sum[DWIDTH] ^ w_sum[DWIDTH-1]) : w_sum[DWIDTH];
    w_new     = w_sum[DWIDTH-1:0];
    if (w_oor && r_sat) begin
      if (!r_signed)          w_new = '1;
      else if (w_sum[DWIDTH]) w_new = {1'b1, {(DWIDTH - 1){1'b0}}};
      else                    w_new = {1'b0, {(DWIDTH - 1){1'b1}}};
    end
    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
      r_ovf    <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_signed <= 1'b0;
      r_sat    <= 1'b0;
      r_idx    <= '0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      ch_o     <= '0;
      result_o <= '0;
      ovf_o    <= 1'b0;
    end else begin
      // Beat outputs are zero except on drain cycles.
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      ch_o     <= '0;
      result_o <= '0;
      ovf_o    <= 1'b0;
      if ((r_state != StDrain) && run_i) begin
        for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
        r_ovf    <= '0;
        r_cnt    <= '0;
        r_idx    <= '0;
        r_len    <= len_i;
        r_signed <= signed_i;
        r_sat    <= sat_i;
        busy_o   <= 1'b1;
        r_state  <= (len_i == '0) ? StDrain : StAcc;
      end else begin
        unique case (r_state)
          StIdle: busy_o <= 1'b0;
          StAcc: begin
            busy_o <= 1'b1;
            if (w_accept) begin
              r_acc[w_sel_ch] <= w_new;
              if (w_oor) r_ovf[w_sel_ch] <= 1'b1;
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == r_len) r_state <= StDrain;
            end
          end
          StDrain: begin
            busy_o   <= 1'b1;
            valid_o  <= 1'b1;
            ch_o     <= r_idx;
            result_o <= r_acc[r_idx];
            ovf_o    <= r_ovf[r_idx];
            if (r_idx == ChLast) begin
              last_o  <= 1'b1;
              r_idx   <= '0;
              r_state <= StIdle;
            end else begin
              r_idx <= r_idx + CH_W'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_core_mc.sv
module tb_acc_core_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       run, vld, sgn, sat, sel;
  logic [8:0] len;
  logic [1:0] ch;
  logic [7:0] num;

  // Instance A: 4 channels, 16-bit, 9-bit counter. Instance B: 3 channels, 9-bit, 8-bit counter.
  logic        a_busy, a_valid, a_last, a_ovf;
  logic [1:0]  a_ch;
  logic [15:0] a_res;
  logic        b_busy, b_valid, b_last, b_ovf;
  logic [1:0]  b_ch;
  logic [8:0]  b_res;

  acc_core_mc #(.IN_DATA_WIDTH(8), .DWIDTH(16), .NUM_CH(4), .CNT_WIDTH(9)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .run_i(run & ~sel), .len_i(len), .signed_i(sgn),
    .sat_i(sat), .valid_i(vld), .ch_i(ch), .number_i(num), .busy_o(a_busy),
    .valid_o(a_valid), .last_o(a_last), .ch_o(a_ch), .result_o(a_res), .ovf_o(a_ovf)
  );

  acc_core_mc #(.IN_DATA_WIDTH(8), .DWIDTH(9), .NUM_CH(3), .CNT_WIDTH(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .run_i(run & sel), .len_i(len[7:0]), .signed_i(sgn),
    .sat_i(sat), .valid_i(vld), .ch_i(ch), .number_i(num), .busy_o(b_busy),
    .valid_o(b_valid), .last_o(b_last), .ch_o(b_ch), .result_o(b_res), .ovf_o(b_ovf)
  );

  logic        o_busy, o_valid, o_last, o_ovf;
  logic [1:0]  o_ch;
  logic [15:0] o_res;
  always_comb begin
    o_busy  = sel ? b_busy  : a_busy;
    o_valid = sel ? b_valid : a_valid;
    o_last  = sel ? b_last  : a_last;
    o_ch    = sel ? b_ch    : a_ch;
    o_ovf   = sel ? b_ovf   : a_ovf;
    o_res   = sel ? {7'b0, b_res} : a_res;
  end

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_res [4];
  bit          exp_ovf [4];

  // Reference model: plain integer arithmetic with range clamping / modular wrap.
  longint macc [4];
  bit     movf [4];
  int     mdw;
  bit     msg, mst;

  typedef struct {
    bit          sg;
    bit          st;
    logic [1:0]  c;
    logic [7:0]  a, b, d;
    logic [15:0] res;
    bit          ov;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input bit s, input int l, input bit sg, input bit st);
    sel = s; run = 1'b1; len = 9'(l); sgn = sg; sat = st;
    step();
    run = 1'b0;
  endtask

  task automatic send(input int c, input logic [7:0] v);
    vld = 1'b1; ch = 2'(c); num = v;
    step();
    vld = 1'b0;
  endtask

  task automatic mdl_clear(input int dw, input bit sg, input bit st);
    mdw = dw; msg = sg; mst = st;
    for (int i = 0; i < 4; i++) begin macc[i] = 0; movf[i] = 1'b0; end
  endtask

  task automatic mdl_add(input int c, input logic [7:0] v);
    longint lo, hi, s, m, span;
    span = longint'(1) << mdw;
    if (msg) begin lo = -(span / 2); hi = span / 2 - 1; end
    else begin lo = 0; hi = span - 1; end
    s = macc[c] + (msg ? longint'($signed(v)) : longint'(v));
    if (s < lo || s > hi) begin
      movf[c] = 1'b1;
      if (mst) s = (s < lo) ? lo : hi;
      else begin
        m = s % span;
        if (m < 0) m += span;
        if (m > hi) m -= span;
        s = m;
      end
    end
    macc[c] = s;
  endtask

  task automatic mdl_to_exp();
    for (int i = 0; i < 4; i++) begin
      exp_res[i] = 16'(macc[i] & ((longint'(1) << mdw) - 1));
      exp_ovf[i] = movf[i];
    end
  endtask

  task automatic exp_zero();
    for (int i = 0; i < 4; i++) begin exp_res[i] = '0; exp_ovf[i] = 1'b0; end
  endtask

  // Called at the negedge right after the edge that ends the burst.
  task automatic collect(input string name, input int nch);
    int t = 0;
    while (!o_valid && t < 20) begin step(); t++; end
    chk($sformatf("%s drain latency", name), t, 1);
    if (!o_valid) return;
    for (int k = 0; k < nch; k++) begin
      chk($sformatf("%s b%0d valid", name, k), o_valid, 1);
      chk($sformatf("%s b%0d ch", name, k), o_ch, k);
      chk($sformatf("%s b%0d res", name, k), o_res, exp_res[k]);
      chk($sformatf("%s b%0d ovf", name, k), o_ovf, exp_ovf[k]);
      chk($sformatf("%s b%0d last", name, k), o_last, (k == nch - 1));
      chk($sformatf("%s b%0d busy", name, k), o_busy, 1);
      step();
    end
    chk($sformatf("%s end valid", name), o_valid, 0);
    chk($sformatf("%s end busy", name), o_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 2'd0, 8'd10,  8'd20,  8'd30,  16'h03C, 0};
    tbl[1]  = '{0, 0, 2'd1, 8'hFF,  8'hFF,  8'hFF,  16'h0FD, 1};
    tbl[2]  = '{0, 1, 2'd2, 8'hFF,  8'hFF,  8'hFF,  16'h1FF, 1};
    tbl[3]  = '{1, 1, 2'd2, 8'h80,  8'h80,  8'h80,  16'h100, 1};
    tbl[4]  = '{1, 0, 2'd0, 8'h80,  8'h80,  8'h80,  16'h080, 1};
    tbl[5]  = '{1, 1, 2'd1, 8'h7F,  8'h7F,  8'h7F,  16'h0FF, 1};
    tbl[6]  = '{1, 0, 2'd1, 8'h7F,  8'h7F,  8'h7F,  16'h17D, 1};
    tbl[7]  = '{1, 1, 2'd0, 8'hFF,  8'hFF,  8'h05,  16'h003, 0};
    tbl[8]  = '{0, 1, 2'd2, 8'd200, 8'd100, 8'd50,  16'h15E, 0};
    tbl[9]  = '{1, 1, 2'd2, 8'h7F,  8'h7F,  8'h81,  16'h07F, 0};
    tbl[10] = '{0, 0, 2'd0, 8'hFF,  8'hFF,  8'h02,  16'h000, 1};
    tbl[11] = '{1, 0, 2'd1, 8'h80,  8'h80,  8'h7F,  16'h17F, 0};

    reset_n = 1'b0; run = 0; vld = 0; sgn = 0; sat = 0; sel = 0; len = '0; ch = '0; num = '0;
    #1;
    chk("reset a busy", a_busy, 0);
    chk("reset a valid", a_valid, 0);
    chk("reset a last", a_last, 0);
    chk("reset a ch", a_ch, 0);
    chk("reset a res", a_res, 0);
    chk("reset a ovf", a_ovf, 0);
    chk("reset b valid", b_valid, 0);
    chk("reset b res", b_res, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();

    // Basic unsigned wrap burst across channels.
    start(0, 4, 0, 0);
    chk("basic busy after run", o_busy, 1);
    send(0, 8'd10); send(1, 8'd20); send(0, 8'd5); send(3, 8'd255);
    exp_zero(); exp_res[0] = 16'd15; exp_res[1] = 16'd20; exp_res[3] = 16'd255;
    collect("basic", 4);

    // Long unsigned burst: wrap then saturate.
    start(0, 258, 0, 0);
    repeat (258) send(0, 8'hFF);
    exp_zero(); exp_res[0] = 16'd254; exp_ovf[0] = 1;
    collect("uwrap258", 4);
    start(0, 258, 0, 1);
    repeat (258) send(0, 8'hFF);
    exp_zero(); exp_res[0] = 16'hFFFF; exp_ovf[0] = 1;
    collect("usat258", 4);

    // Table of 3-sample bursts on the 9-bit instance.
    for (int i = 0; i < 12; i++) begin
      start(1, 3, tbl[i].sg, tbl[i].st);
      send(tbl[i].c, tbl[i].a); send(tbl[i].c, tbl[i].b); send(tbl[i].c, tbl[i].d);
      exp_zero(); exp_res[tbl[i].c] = tbl[i].res; exp_ovf[tbl[i].c] = tbl[i].ov;
      collect($sformatf("tbl%0d", i), 3);
    end

    // Restart with a coincident sample: the sample is discarded.
    start(0, 3, 0, 0);
    send(0, 8'd11); send(2, 8'd22);
    run = 1'b1; len = 9'd1; vld = 1'b1; ch = 2'd1; num = 8'd50;
    step();
    run = 1'b0; vld = 1'b0;
    chk("restart busy", o_busy, 1);
    send(1, 8'd7);
    exp_zero(); exp_res[1] = 16'd7;
    collect("restart", 4);

    // Zero-length burst after a burst left nonzero state.
    start(0, 5, 0, 0);
    send(0, 8'd1); send(1, 8'd2); send(2, 8'd3); send(3, 8'd4); send(0, 8'd5);
    exp_zero(); exp_res[0] = 16'd6; exp_res[1] = 16'd2; exp_res[2] = 16'd3; exp_res[3] = 16'd4;
    collect("prelen0", 4);
    start(0, 0, 0, 0);
    exp_zero();
    collect("len0", 4);

    // Out-of-range channel on the 3-channel instance is neither counted nor summed.
    start(1, 2, 0, 0);
    send(3, 8'd99); send(0, 8'd4); send(3, 8'd50);
    chk("badch still busy", o_busy, 1);
    chk("badch no drain", o_valid, 0);
    send(1, 8'd6);
    exp_zero(); exp_res[0] = 16'd4; exp_res[1] = 16'd6;
    collect("badch", 3);

    // Randomized bursts against the model.
    for (int i = 0; i < 40; i++) begin
      bit s, sg, st;
      int nch, l, cnt, c;
      logic [7:0] v;
      s = i[0]; nch = s ? 3 : 4;
      sg = 1'($urandom); st = 1'($urandom);
      l = $urandom_range(1, 24);
      start(s, l, sg, st);
      mdl_clear(s ? 9 : 16, sg, st);
      cnt = 0;
      while (cnt < l) begin
        if ($urandom_range(0, 3) == 0) step();
        else begin
          c = $urandom_range(0, 3);
          v = 8'($urandom);
          send(c, v);
          if (c < nch) begin mdl_add(c, v); cnt++; end
        end
      end
      mdl_to_exp();
      collect($sformatf("rnd%0d", i), nch);
    end

    // Reset in the middle of a drain.
    start(0, 1, 0, 0);
    send(2, 8'd9);
    step();
    chk("rstdrain beat seen", o_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rstdrain busy", o_busy, 0);
    chk("rstdrain valid", o_valid, 0);
    chk("rstdrain last", o_last, 0);
    chk("rstdrain ch", o_ch, 0);
    chk("rstdrain res", o_res, 0);
    chk("rstdrain ovf", o_ovf, 0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int seen = 0;
      repeat (6) begin step(); if (o_valid || o_busy) seen++; end
      chk("rstdrain no resume", seen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
